// File: rtl/datamem_wbuf_if.sv
// MEM-stage data-memory port bundle shared by the core (master) and datamem_wbuf (slave).
// wbuf_drain_hold inhibits queue retirement; tie it low in normal operation.
interface datamem_wbuf_if #(
  parameter int AW    = 7,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] datamem_rd_addr0;
  logic          datamem_rd_en;
  logic [31:0]   datamem_rd_dout0;
  logic [AW-1:0] datamem_wr_addr0;
  logic [31:0]   datamem_wr_din0;
  logic          datamem_we0;
  logic [2:0]    datamem_wr_strb;
  logic          datamem_stall;
  logic [CW-1:0] wbuf_count;
  logic          wbuf_empty;
  logic          wbuf_drain_hold;

  modport master (
    output datamem_rd_addr0, datamem_rd_en,
    output datamem_wr_addr0, datamem_wr_din0, datamem_we0, datamem_wr_strb,
    output wbuf_drain_hold,
    input  datamem_rd_dout0, datamem_stall, wbuf_count, wbuf_empty
  );

  modport slave (
    input  datamem_rd_addr0, datamem_rd_en,
    input  datamem_wr_addr0, datamem_wr_din0, datamem_we0, datamem_wr_strb,
    input  wbuf_drain_hold,
    output datamem_rd_dout0, datamem_stall, wbuf_count, wbuf_empty
  );
endinterface

// File: rtl/datamem_wbuf.sv
// Data-memory responder: byte-masked stores are posted to a circular queue that retires one entry per
// cycle into a 2^AW x 32 array. Define DATAMEM_WBUF_FWD_EN to merge queued stores into loads.
module datamem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 7
) (
  input logic           clk,
  input logic           rst,
  datamem_wbuf_if.slave bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
    logic          valid;
  } entry_t;

  entry_t        entry_q [DEPTH];
  logic [31:0]   mem_q   [WORDS];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [3:0]    st_mask;
  logic [31:0]   st_data;
  logic          full;
  logic          enq;
  logic          drain;
  logic          store_stall;
  logic [31:0]   rd_data;
  entry_t        head_e;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    st_mask = 4'b0000;
    st_data = bus.datamem_wr_din0;
    casez (bus.datamem_wr_strb)
      3'b000: st_mask = 4'b1111;
      3'b0?1: begin
        st_mask = bus.datamem_wr_strb[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.datamem_wr_din0[15:0]}};
      end
      3'b1??: begin
        st_mask = 4'b0001 << bus.datamem_wr_strb[1:0];
        st_data = {4{bus.datamem_wr_din0[7:0]}};
      end
      default: st_mask = 4'b0000;  // 010 is reserved and posts nothing
    endcase
  end

  assign full        = (count_q == CW'(DEPTH));
  assign enq         = bus.datamem_we0 && (st_mask != 4'b0000) && !full;
  assign drain       = (count_q != '0) && !bus.wbuf_drain_hold;
  assign store_stall = bus.datamem_we0 && (st_mask != 4'b0000) && full;
  assign head_e      = entry_q[head_q];

  assign head_d  = drain ? head_q + PW'(1) : head_q;
  assign tail_d  = enq   ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(enq) - CW'(drain);

  // Loads see the array overlaid by queued stores, walked oldest to youngest so the youngest byte wins.
  always_comb begin
    rd_data = mem_q[bus.datamem_rd_addr0];
`ifdef DATAMEM_WBUF_FWD_EN
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (entry_q[head_q + PW'(k)].valid &&
            entry_q[head_q + PW'(k)].addr == bus.datamem_rd_addr0 &&
            entry_q[head_q + PW'(k)].mask[b]) begin
          rd_data[8*b +: 8] = entry_q[head_q + PW'(k)].data[8*b +: 8];
        end
      end
    end
`endif
  end

`ifdef DATAMEM_WBUF_FWD_EN
  assign bus.datamem_stall = store_stall;
`else
  logic load_hit;

  always_comb begin
    load_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_q[k].valid && entry_q[k].addr == bus.datamem_rd_addr0) load_hit = 1'b1;
    end
  end

  // Without forwarding a load must wait until every pending store to its word has retired.
  assign bus.datamem_stall = store_stall || (bus.datamem_rd_en && load_hit);
`endif

  assign bus.datamem_rd_dout0 = rd_data;
  assign bus.wbuf_count       = count_q;
  assign bus.wbuf_empty       = (count_q == '0);

  // NOTE: state uses non-blocking assignments only; the array is reset word by word because a reset
  // must leave every location reading zero, which rules out mapping it onto a plain SRAM macro.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) entry_q[k] <= '0;
      for (int w = 0; w < WORDS; w++) mem_q[w] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (drain) begin
        for (int b = 0; b < 4; b++) begin
          if (head_e.mask[b]) mem_q[head_e.addr][8*b +: 8] <= head_e.data[8*b +: 8];
        end
        entry_q[head_q].valid <= 1'b0;
      end
      // Enqueue and drain never target the same slot: drain needs count>0, enqueue needs count<DEPTH.
      if (enq) begin
        entry_q[tail_q] <= '{addr: bus.datamem_wr_addr0, data: st_data, mask: st_mask, valid: 1'b1};
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_datamem_wbuf.sv
// Self-checking bench for datamem_wbuf: directed scenarios then random traffic, all compared against
// a queue-and-array reference model evaluated once per cycle.
module tb_datamem_wbuf;
  localparam int AW    = 7;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datamem_wbuf_if #(.AW(AW), .DEPTH(DEPTH)) bus ();
  datamem_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    mask;
  } store_t;

  store_t      ref_q[$];
  logic [31:0] ref_mem [1 << AW];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Store size/lane rules expressed directly: size from the top bits, lane from the low bits.
  function automatic void decode(input logic [2:0] strb, input logic [31:0] din,
                                 output logic [3:0] m, output logic [31:0] d);
    if (strb == 3'b000) begin
      m = 4'hF; d = din;
    end else if (strb == 3'b010) begin
      m = 4'h0; d = din;
    end else if (strb[2] == 1'b0) begin
      m = strb[1] ? 4'b1100 : 4'b0011;
      d = {din[15:0], din[15:0]};
    end else begin
      m = 4'(1 << strb[1:0]);
      d = {din[7:0], din[7:0], din[7:0], din[7:0]};
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r = w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_dout(input logic [AW-1:0] a);
    logic [31:0] r = ref_mem[a];
`ifdef DATAMEM_WBUF_FWD_EN
    foreach (ref_q[i]) if (ref_q[i].addr == a) r = merge(r, ref_q[i].data, ref_q[i].mask);
`endif
    return r;
  endfunction

  function automatic logic exp_stall();
    logic [3:0]  m;
    logic [31:0] d;
    logic        s;
    decode(bus.datamem_wr_strb, bus.datamem_wr_din0, m, d);
    s = bus.datamem_we0 && (m != 4'h0) && (ref_q.size() == DEPTH);
`ifndef DATAMEM_WBUF_FWD_EN
    foreach (ref_q[i]) if (bus.datamem_rd_en && ref_q[i].addr == bus.datamem_rd_addr0) s = 1'b1;
`endif
    return s;
  endfunction

  task automatic check_outputs();
    #1;
    check("dout",  bus.datamem_rd_dout0, exp_dout(bus.datamem_rd_addr0));
    check("stall", 32'(bus.datamem_stall), 32'(exp_stall()));
    check("count", 32'(bus.wbuf_count), 32'(ref_q.size()));
    check("empty", 32'(bus.wbuf_empty), 32'(ref_q.size() == 0));
  endtask

  // One clock: the model takes the same edge as the DUT, then inputs may change at the falling edge.
  task automatic advance();
    logic [3:0]  m;
    logic [31:0] d;
    bit          enq_ok;
    store_t      st;
    @(posedge clk);
    decode(bus.datamem_wr_strb, bus.datamem_wr_din0, m, d);
    if (!rst) begin
      ref_q.delete();
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      enq_ok = bus.datamem_we0 && (m != 4'h0) && (ref_q.size() < DEPTH);
      if (ref_q.size() > 0 && !bus.wbuf_drain_hold) begin
        st = ref_q.pop_front();
        ref_mem[st.addr] = merge(ref_mem[st.addr], st.data, st.mask);
      end
      if (enq_ok) ref_q.push_back('{addr: bus.datamem_wr_addr0, data: d, mask: m});
    end
    @(negedge clk);
  endtask

  task automatic set_store(input logic we, input logic [2:0] strb, input logic [AW-1:0] addr,
                           input logic [31:0] din);
    bus.datamem_we0      = we;
    bus.datamem_wr_strb  = strb;
    bus.datamem_wr_addr0 = addr;
    bus.datamem_wr_din0  = din;
  endtask

  task automatic set_load(input logic en, input logic [AW-1:0] addr);
    bus.datamem_rd_en    = en;
    bus.datamem_rd_addr0 = addr;
  endtask

  task automatic wait_empty();
    set_store(1'b0, 3'b000, '0, '0);
    for (int i = 0; i < 16 && !bus.wbuf_empty; i++) advance();
    #1;
    check("wait_empty", 32'(bus.wbuf_empty), 32'd1);
  endtask

  initial begin
    rst = 1'b0;
    bus.wbuf_drain_hold = 1'b0;
    set_store(1'b0, 3'b000, '0, '0);
    set_load(1'b0, '0);
    @(negedge clk);
    advance();
    advance();
    rst = 1'b1;

    // Post-reset load
    set_load(1'b1, 7'd5);
    check_outputs();
    check("rst_dout", bus.datamem_rd_dout0, 32'h0);
    check("rst_empty", 32'(bus.wbuf_empty), 32'd1);
    check("rst_stall", 32'(bus.datamem_stall), 32'd0);
    advance();

    // Word store then load of the same word next cycle
    set_load(1'b0, '0);
    set_store(1'b1, 3'b000, 7'd3, 32'hDEADBEEF);
    check_outputs();
    advance();
    set_store(1'b0, 3'b000, '0, '0);
    set_load(1'b1, 7'd3);
    check_outputs();
`ifdef DATAMEM_WBUF_FWD_EN
    check("fwd3_stall", 32'(bus.datamem_stall), 32'd0);
    check("fwd3_dout", bus.datamem_rd_dout0, 32'hDEADBEEF);
`else
    check("haz3_stall", 32'(bus.datamem_stall), 32'd1);
    advance();
    check_outputs();
    check("haz3_stall_clr", 32'(bus.datamem_stall), 32'd0);
    check("haz3_dout", bus.datamem_rd_dout0, 32'hDEADBEEF);
`endif
    advance();

    // Word, byte lane 2, half lane 0 to the same word back to back
    set_load(1'b0, '0);
    set_store(1'b1, 3'b000, 7'd7, 32'h11223344); check_outputs(); advance();
    set_store(1'b1, 3'b110, 7'd7, 32'h000000AA); check_outputs(); advance();
    set_store(1'b1, 3'b001, 7'd7, 32'h0000BEEF); check_outputs(); advance();
    set_store(1'b0, 3'b000, '0, '0);
    set_load(1'b1, 7'd7);
    check_outputs();
    for (int i = 0; i < 8 && bus.datamem_stall; i++) begin
      advance();
      check_outputs();
    end
    check("merge7_stall", 32'(bus.datamem_stall), 32'd0);
    check("merge7_dout", bus.datamem_rd_dout0, 32'h11AABEEF);
    set_load(1'b0, '0);
    advance();
    wait_empty();
    set_load(1'b1, 7'd7);
    check_outputs();
    check("array7", bus.datamem_rd_dout0, 32'h11AABEEF);
    advance();

    // Fill the queue with retirement held, then present one more store
    set_load(1'b0, '0);
    bus.wbuf_drain_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      set_store(1'b1, 3'b000, AW'(10 + i), $urandom);
      check_outputs();
      advance();
    end
    set_store(1'b1, 3'b000, 7'd14, 32'hCAFEF00D);
    check_outputs();
    check("full_stall", 32'(bus.datamem_stall), 32'd1);
    check("full_count", 32'(bus.wbuf_count), 32'(DEPTH));
    advance();
    check_outputs();
    check("held_stall", 32'(bus.datamem_stall), 32'd1);
    check("held_count", 32'(bus.wbuf_count), 32'(DEPTH));
    bus.wbuf_drain_hold = 1'b0;
    advance();
    check_outputs();
    check("release_stall", 32'(bus.datamem_stall), 32'd0);
    advance();
    set_store(1'b0, 3'b000, '0, '0);
    check_outputs();
    check("accept_count", 32'(bus.wbuf_count), 32'(DEPTH - 1));
    advance();
    wait_empty();
    set_load(1'b1, 7'd14);
    check_outputs();
    check("accepted14", bus.datamem_rd_dout0, 32'hCAFEF00D);
    advance();

    // Reserved strobe
    set_load(1'b0, '0);
    set_store(1'b1, 3'b010, 7'd20, 32'h12345678);
    check_outputs();
    check("rsv_stall", 32'(bus.datamem_stall), 32'd0);
    advance();
    set_store(1'b0, 3'b000, '0, '0);
    set_load(1'b1, 7'd20);
    check_outputs();
    check("rsv_count", 32'(bus.wbuf_count), 32'd0);
    check("rsv_dout", bus.datamem_rd_dout0, 32'h0);
    advance();

    // Reset discards pending stores and clears the array
    set_load(1'b0, '0);
    bus.wbuf_drain_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 3'b000, AW'(30 + i), 32'hA5A50000 + 32'(i));
      check_outputs();
      advance();
    end
    set_store(1'b0, 3'b000, '0, '0);
    rst = 1'b0;
    advance();
    rst = 1'b1;
    bus.wbuf_drain_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_load(1'b1, AW'(30 + i));
      check_outputs();
      check("post_rst_count", 32'(bus.wbuf_count), 32'd0);
      check("post_rst_dout", bus.datamem_rd_dout0, 32'h0);
      advance();
    end
    set_load(1'b1, 7'd7);
    check_outputs();
    check("post_rst_dout7", bus.datamem_rd_dout0, 32'h0);
    advance();

    // Random traffic over a few addresses so queue hits, merges and full stalls all occur
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) != 0);
      bus.wbuf_drain_hold = ($urandom_range(0, 3) == 0);
      set_store($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom);
      set_load($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)));
      check_outputs();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end
endmodule
